// File: rtl/key_pkg.sv
// Shared types and default timing for the pushbutton conditioner.
package key_pkg;

  typedef enum logic [1:0] {KS_IDLE, KS_DELAY, KS_REPEAT} key_state_e;

  localparam int KEY_DEBOUNCE_DEF = 500_000;
  localparam int KEY_DELAY_DEF    = 25_000_000;
  localparam int KEY_RATE_DEF     = 5_000_000;

  function automatic int key_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One pushbutton: synchronizer, debounce, press/release edges and optional
// auto-repeat (compiled in when KEY_AUTOREPEAT_EN is defined).
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = KEY_DELAY_DEF,
  parameter int REPEAT_RATE     = KEY_RATE_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press,
  output logic release_pulse,
  output logic rpt
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] cnt;
  logic          settle;
  logic          rise;
  logic          fall;

  assign s      = ~sync[1];
  assign settle = (s != pressed) && (cnt == CW'(DEBOUNCE_CYCLES - 1));
  assign rise   = settle & s;
  assign fall   = settle & ~s;

  // Edge pulses are registered from the settle condition so they coincide with the level change.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync          <= 2'b11;
      pressed       <= 1'b0;
      cnt           <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[0], key_n};
      press         <= rise;
      release_pulse <= fall;
      if (s == pressed) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        pressed <= s;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = (key_max(REPEAT_DELAY, REPEAT_RATE) > 1) ?
                      $clog2(key_max(REPEAT_DELAY, REPEAT_RATE)) : 1;

  key_state_e    state, state_n;
  logic [RW-1:0] rc, rc_n;
  logic          rpt_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= KS_IDLE;
      rc    <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_n;
      rc    <= rc_n;
      rpt   <= rpt_n;
    end
  end

  always_comb begin
    state_n = state;
    rc_n    = rc;
    rpt_n   = 1'b0;
    case (state)
      KS_IDLE: begin
        if (rise) begin
          state_n = KS_DELAY;
          rc_n    = '0;
          rpt_n   = 1'b1;
        end
      end
      KS_DELAY: begin
        if (rc == RW'(REPEAT_DELAY - 1)) begin
          state_n = KS_REPEAT;
          rc_n    = '0;
          rpt_n   = 1'b1;
        end else begin
          rc_n = rc + RW'(1);
        end
      end
      KS_REPEAT: begin
        if (rc == RW'(REPEAT_RATE - 1)) begin
          rc_n  = '0;
          rpt_n = 1'b1;
        end else begin
          rc_n = rc + RW'(1);
        end
      end
      default: begin
        state_n = KS_IDLE;
        rc_n    = '0;
      end
    endcase
    // Release beats a repeat that lands on the same cycle.
    if (fall) begin
      state_n = KS_IDLE;
      rc_n    = '0;
      rpt_n   = 1'b0;
    end
  end
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
  assign rpt = press;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Conditions NKEYS raw active-low pushbuttons into clean levels and pulses.
// Auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module key_conditioner
  import key_pkg::*;
#(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEF,
  parameter int REPEAT_DELAY    = KEY_DELAY_DEF,
  parameter int REPEAT_RATE     = KEY_RATE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  output logic [NKEYS-1:0] pressed,
  output logic [NKEYS-1:0] press,
  output logic [NKEYS-1:0] release_pulse,
  output logic [NKEYS-1:0] rpt
);

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_channel (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n[i]),
      .pressed      (pressed[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .rpt          (rpt[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: a window-based reference model predicts
// every cycle's outputs; a monitor compares them against the DUT.
module tb_key_conditioner;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] pressed, press, release_pulse, rpt;

  typedef struct packed {
    logic [NK-1:0] pressed;
    logic [NK-1:0] press;
    logic [NK-1:0] rel;
    logic [NK-1:0] rpt;
  } exp_t;

  exp_t sb[$];
  int   assert_count = 0;
  int   fail_count   = 0;
  bit   model_on     = 1'b0;

  always #5 clk = ~clk;

  key_conditioner #(
    .NKEYS          (NK),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .pressed      (pressed),
    .press        (press),
    .release_pulse(release_pulse),
    .rpt          (rpt)
  );

  task automatic checkOutput(input string name, input logic [NK-1:0] actual,
                             input logic [NK-1:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NK-1:0] kn, input logic rst, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      key_n = kn;
      reset = rst;
    end
  endtask

  // Reference model: a key's level flips once the synchronized input has shown
  // the other level for DB consecutive samples; repeats follow press-time arithmetic.
  initial begin
    bit   h[NK][DB+2];
    bit   mp[NK];
    int   pt[NK];
    int   cyc;
    int   off;
    bit   prev;
    bit   flip;
    exp_t e;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      e = '0;
      if (reset) begin
        model_on = 1'b1;
        for (int k = 0; k < NK; k++) begin
          for (int j = 0; j < DB + 2; j++) h[k][j] = 1'b1;
          mp[k] = 1'b0;
          pt[k] = 0;
        end
      end else if (model_on) begin
        for (int k = 0; k < NK; k++) begin
          for (int j = DB + 1; j > 0; j--) h[k][j] = h[k][j-1];
          h[k][0] = key_n[k];
          flip = 1'b1;
          for (int j = 2; j < DB + 2; j++) if (h[k][j] != mp[k]) flip = 1'b0;
          prev = mp[k];
          if (flip) mp[k] = ~mp[k];
          e.pressed[k] = mp[k];
          e.press[k]   = mp[k] & ~prev;
          e.rel[k]     = ~mp[k] & prev;
          if (e.press[k]) pt[k] = cyc;
          off = cyc - pt[k];
`ifdef KEY_AUTOREPEAT_EN
          e.rpt[k] = mp[k] && ((off == 0) || (off >= RD && ((off - RD) % RR) == 0));
`else
          e.rpt[k] = e.press[k];
`endif
        end
      end
      if (model_on) sb.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("pressed", pressed, e.pressed);
        checkOutput("press", press, e.press);
        checkOutput("release", release_pulse, e.rel);
        checkOutput("rpt", rpt, e.rpt);
      end
    end
  end

  initial begin
    logic [NK-1:0] kn;
    logic          rst;
    $display("[TB] key_conditioner bench starting");
    applyStimulus(4'hF, 1'b1, 2);
    applyStimulus(4'hF, 1'b0, 20);
    // clean press and release
    applyStimulus(4'hE, 1'b0, 20);
    applyStimulus(4'hF, 1'b0, 15);
    // bounce on key0
    applyStimulus(4'hE, 1'b0, 3);
    applyStimulus(4'hF, 1'b0, 1);
    applyStimulus(4'hE, 1'b0, 3);
    applyStimulus(4'hF, 1'b0, 1);
    applyStimulus(4'hE, 1'b0, 15);
    applyStimulus(4'hF, 1'b0, 12);
    // long hold
    applyStimulus(4'hE, 1'b0, 40);
    applyStimulus(4'hF, 1'b0, 12);
    // simultaneous press, key0 released early
    applyStimulus(4'hC, 1'b0, 11);
    applyStimulus(4'hD, 1'b0, 25);
    applyStimulus(4'hF, 1'b0, 12);
    // reset while key0 held
    applyStimulus(4'hE, 1'b0, 18);
    applyStimulus(4'hE, 1'b1, 1);
    applyStimulus(4'hE, 1'b0, 15);
    applyStimulus(4'hF, 1'b0, 12);
    // random bouncy keys with rare resets
    kn = '1;
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 4) == 0) kn[k] = ~kn[k];
      rst = ($urandom_range(0, 249) == 0);
      applyStimulus(kn, rst, 1);
    end
    // random long holds to exercise repeats
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NK; k++) if ($urandom_range(0, 24) == 0) kn[k] = ~kn[k];
      applyStimulus(kn, 1'b0, 1);
    end
    applyStimulus(4'hF, 1'b0, 12);
    @(negedge clk);
    #1;
    assert_count++;
    if (sb.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
